tiny16_mem_arbiter: RTL
=======================

// Module: tiny16_mem_arbiter
// PURPOSE
//  Shares the single-port 16-bit tiny16 memory between instruction fetch (IF), load/store (LS)
//  and an optional debug/loader port (DBG). One access in flight at a time; registered
//  ownership with a req/gnt/rvalid handshake. Sits between the CPU core and the memory array.
// PARAMETERS
//  AW         16  memory address width
//  DW         16  data width (tiny16 word)
//  RD_LAT     1   memory read latency in cycles, 1..3: mem_rdata valid RD_LAT cycles after mem_en
//  STARVE_MAX 4   consecutive lost arbitrations before IF is forced to win, >=1
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   synchronous reset, active-high
//  if_req     in   1   fetch request (read only); hold with if_addr until if_gnt
//  if_addr    in   AW  fetch address
//  if_gnt     out  1   one-cycle pulse: access issued to memory this cycle
//  if_rvalid  out  1   one-cycle pulse: if_rdata valid
//  if_rdata   out  DW  read data (mem_rdata passthrough)
//  ls_req / ls_we / ls_addr / ls_wdata  in  1/1/AW/DW  load/store request; hold all until ls_gnt
//  ls_gnt / ls_rvalid / ls_rdata  out  1/1/DW  as for IF; no rvalid for writes
//  dbg_req / dbg_we / dbg_addr / dbg_wdata / dbg_gnt / dbg_rvalid / dbg_rdata  as LS (macro only)
//  mem_en / mem_we / mem_addr / mem_wdata  out  1/1/AW/DW  memory strobe and command
//  mem_rdata  in   DW  memory read data
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - FSM: IDLE, ACCESS, WAIT, RESP. owner register: IF, LS or DBG.
//  - Arbitrate at any edge that ends IDLE, ACCESS-with-write, or RESP. Winner -> owner; next ACCESS.
//  - IDLE with no req: stay IDLE. A req first seen high at the end of cycle c gives gnt in cycle c+1.
//  - ACCESS: mem_en=1; mem_we/addr/wdata from owner's live inputs; gnt_owner=1.
//    Write -> arbitrate (back-to-back: the next ACCESS is possible in the very next cycle).
//    Read -> WAIT for RD_LAT-1 cycles, then RESP. RD_LAT=1 goes straight to RESP.
//  - RESP: rvalid_owner=1, rdata_owner=mem_rdata. Then arbitrate.
//  - Priority: DBG > LS > IF. Starvation override: starve_cnt increments on each arbitration where
//    IF requests and loses. It clears when IF wins or if_req=0. When starve_cnt==STARVE_MAX,
//    IF wins over LS (not over DBG).
//  - Withdrawing a req before its gnt is a protocol violation. The bench flags it; RTL behaviour is undefined.
//  - Write-then-read to the same address: the read sees the new data. Accesses are strictly serialized.
//  - rdata outputs are don't-care when rvalid=0. Bench checks only under rvalid.
//  - Reset values: state=IDLE, owner=IF, starve_cnt=0; all gnt, rvalid and mem_en/mem_we are 0;
//    busy=0; mem_addr/mem_wdata are 0.
//  - RST mid-operation: an in-flight read is dropped with no rvalid. IDLE in the cycle after RST.
//  - RST high with reqs pending: no gnt until the cycle after RST falls.
// CONFIGURATION
//  TINY16_ARB_DBG_EN defined: DBG port is present and has highest priority. It can load the
//    program while the core is held stalled.
//  TINY16_ARB_DBG_EN undefined: dbg_* ports are absent; two-way LS/IF arbitration; otherwise identical.
// STRUCTURE
//  tiny16_pkg: arb_state_t enum (IDLE/ACCESS/WAIT/RESP), arb_owner_t enum (IF/LS/DBG),
//    constants for AW/DW defaults.
//  Sub-module tiny16_arb_pick: combinational priority plus starvation-override picker.
//    It takes reqs and starve_cnt==STARVE_MAX and returns the winner.
// TESTING
//  1 Reset: RST=1 for 2 cycles with if_req=ls_req=1 -> no gnt, mem_en=0; first ls_gnt in the cycle after RST falls.
//  2 IF read, RD_LAT=1, mem[0x0002]=0x3430 -> if_gnt at cycle k; if_rvalid=1 with if_rdata=0x3430 at k+1.
//  3 Same-cycle IF read 0x0010 + LS write 0x0010<-0xBEEF -> ls_gnt at k; if_gnt at k+1; if_rdata=0xBEEF at k+2.
//  4 ls_req held high for 10 writes, if_req high -> exactly 4 ls_gnt, then if_gnt; starve_cnt returns to 0.
//  5 RD_LAT=3, RST pulsed in the first WAIT cycle -> no if_rvalid ever; busy=0 in the next cycle.
//  6 With TINY16_ARB_DBG_EN, all three reqs in the same cycle (single accesses, no reassertion) -> gnt order DBG, LS, IF.
//    Without the macro, the build passes and LS/IF order is kept.

Source files
------------

// File: rtl/tiny16_mem_arbiter_pkg.sv
// Shared types and defaults for the tiny16 memory arbiter.
package tiny16_mem_arbiter_pkg;

    localparam int ARB_AW_DEF = 16;
    localparam int ARB_DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_IF  = 2'd0,
        OWN_LS  = 2'd1,
        OWN_DBG = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/tiny16_mem_arbiter_if.sv
// Requester and memory bus of the tiny16 memory arbiter.
// The dbg_* group exists only when TINY16_ARB_DBG_EN is defined.
interface tiny16_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

`ifdef TINY16_ARB_DBG_EN
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
`endif

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requesters plus the memory array
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
`ifdef TINY16_ARB_DBG_EN
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
`endif
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // The arbiter
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
`ifdef TINY16_ARB_DBG_EN
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
`endif
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/tiny16_mem_arbiter_pick.sv
// Priority picker: DBG > LS > IF, except IF beats LS once it has starved.
module tiny16_mem_arbiter_pick
    import tiny16_mem_arbiter_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_ls_req,
    input  logic       i_dbg_req,
    input  logic       i_starve_hit,
    output logic       o_valid,
    output arb_owner_t o_owner
);

    // Resolve the winner among the live requests
    always_comb begin
        o_valid = 1'b1;
        o_owner = OWN_IF;
        if (i_dbg_req) begin
            o_owner = OWN_DBG;
        end else if (i_ls_req && !(i_if_req && i_starve_hit)) begin
            o_owner = OWN_LS;
        end else if (i_if_req) begin
            o_owner = OWN_IF;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/tiny16_mem_arbiter.sv
// Single-port tiny16 memory arbiter between fetch, load/store and (with
// TINY16_ARB_DBG_EN defined) a debug/loader port; one access in flight.
module tiny16_mem_arbiter
    import tiny16_mem_arbiter_pkg::*;
#(
    parameter int AW         = ARB_AW_DEF,
    parameter int DW         = ARB_DW_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    tiny16_mem_arbiter_if.slave  io_bus,
    output logic                 o_busy
);

    localparam int SCW = $clog2(STARVE_MAX + 1);

    arb_state_t    r_state;
    arb_owner_t    r_owner;
    logic [SCW-1:0] r_starve_cnt;
    logic [1:0]    r_wait_cnt;
    logic          r_busy;
    logic          r_if_gnt;
    logic          r_ls_gnt;
    logic          r_if_rvalid;
    logic          r_ls_rvalid;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_dbg_req;
    logic          w_dbg_we;
    logic [AW-1:0] w_dbg_addr;
    logic [DW-1:0] w_dbg_wdata;
    logic          w_starve_hit;
    logic          w_pick_valid;
    arb_owner_t    w_pick_owner;
    logic          w_win_we;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;
    logic          w_arb_now;
    logic          w_to_resp;

`ifdef TINY16_ARB_DBG_EN
    logic          r_dbg_gnt;
    logic          r_dbg_rvalid;

    assign w_dbg_req            = io_bus.dbg_req;
    assign w_dbg_we             = io_bus.dbg_we;
    assign w_dbg_addr           = io_bus.dbg_addr;
    assign w_dbg_wdata          = io_bus.dbg_wdata;
    assign io_bus.dbg_gnt       = r_dbg_gnt;
    assign io_bus.dbg_rvalid    = r_dbg_rvalid;
    assign io_bus.dbg_rdata     = io_bus.mem_rdata;
`else
    assign w_dbg_req            = 1'b0;
    assign w_dbg_we             = 1'b0;
    assign w_dbg_addr           = {AW{1'b0}};
    assign w_dbg_wdata          = {DW{1'b0}};
`endif

    assign io_bus.if_gnt    = r_if_gnt;
    assign io_bus.if_rvalid = r_if_rvalid;
    assign io_bus.if_rdata  = io_bus.mem_rdata;
    assign io_bus.ls_gnt    = r_ls_gnt;
    assign io_bus.ls_rvalid = r_ls_rvalid;
    assign io_bus.ls_rdata  = io_bus.mem_rdata;
    assign io_bus.mem_en    = r_mem_en;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign o_busy           = r_busy;

    assign w_starve_hit = (r_starve_cnt == SCW'(STARVE_MAX));

    // A write frees the memory at once, so the next winner can follow back-to-back.
    assign w_arb_now = (r_state == IDLE) || (r_state == RESP) ||
                       ((r_state == ACCESS) && r_mem_we);
    assign w_to_resp = ((r_state == ACCESS) && !r_mem_we && (RD_LAT == 1)) ||
                       ((r_state == WAIT) && (r_wait_cnt == 2'd0));

    tiny16_mem_arbiter_pick u_pick (
        .i_if_req     (io_bus.if_req),
        .i_ls_req     (io_bus.ls_req),
        .i_dbg_req    (w_dbg_req),
        .i_starve_hit (w_starve_hit),
        .o_valid      (w_pick_valid),
        .o_owner      (w_pick_owner)
    );

    // Command of the requester that wins this arbitration
    always_comb begin
        w_win_we    = 1'b0;
        w_win_addr  = io_bus.if_addr;
        w_win_wdata = {DW{1'b0}};
        case (w_pick_owner)
            OWN_LS: begin
                w_win_we    = io_bus.ls_we;
                w_win_addr  = io_bus.ls_addr;
                w_win_wdata = io_bus.ls_wdata;
            end
            OWN_DBG: begin
                w_win_we    = w_dbg_we;
                w_win_addr  = w_dbg_addr;
                w_win_wdata = w_dbg_wdata;
            end
            default: begin
                w_win_we    = 1'b0;
                w_win_addr  = io_bus.if_addr;
                w_win_wdata = {DW{1'b0}};
            end
        endcase
    end

    // Arbiter FSM with registered grant, response and memory command outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            r_starve_cnt <= {SCW{1'b0}};
            r_wait_cnt   <= 2'd0;
            r_busy       <= 1'b0;
            r_if_gnt     <= 1'b0;
            r_ls_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_ls_rvalid  <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {AW{1'b0}};
            r_mem_wdata  <= {DW{1'b0}};
`ifdef TINY16_ARB_DBG_EN
            r_dbg_gnt    <= 1'b0;
            r_dbg_rvalid <= 1'b0;
`endif
        end else begin
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
`ifdef TINY16_ARB_DBG_EN
            r_dbg_gnt    <= 1'b0;
            r_dbg_rvalid <= 1'b0;
`endif
            if (w_arb_now) begin
                if (w_pick_valid) begin
                    r_state     <= ACCESS;
                    r_busy      <= 1'b1;
                    r_owner     <= w_pick_owner;
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= w_win_we;
                    r_mem_addr  <= w_win_addr;
                    r_mem_wdata <= w_win_wdata;
                    case (w_pick_owner)
                        OWN_LS:  r_ls_gnt  <= 1'b1;
`ifdef TINY16_ARB_DBG_EN
                        OWN_DBG: r_dbg_gnt <= 1'b1;
`endif
                        default: r_if_gnt  <= 1'b1;
                    endcase
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end else begin
                case (r_state)
                    ACCESS: begin
                        r_busy <= 1'b1;
                        if (RD_LAT == 1) begin
                            r_state <= RESP;
                        end else begin
                            r_state    <= WAIT;
                            r_wait_cnt <= 2'(RD_LAT - 2);
                        end
                    end
                    WAIT: begin
                        r_busy <= 1'b1;
                        if (r_wait_cnt == 2'd0) begin
                            r_state <= RESP;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - 2'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            if (w_to_resp) begin
                case (r_owner)
                    OWN_LS:  r_ls_rvalid  <= 1'b1;
`ifdef TINY16_ARB_DBG_EN
                    OWN_DBG: r_dbg_rvalid <= 1'b1;
`endif
                    default: r_if_rvalid  <= 1'b1;
                endcase
            end

            // Counts only arbitrations IF actually lost; saturates while DBG keeps winning.
            if (!io_bus.if_req) begin
                r_starve_cnt <= {SCW{1'b0}};
            end else if (w_arb_now && w_pick_valid) begin
                if (w_pick_owner == OWN_IF) begin
                    r_starve_cnt <= {SCW{1'b0}};
                end else if (!w_starve_hit) begin
                    r_starve_cnt <= r_starve_cnt + SCW'(1);
                end else begin
                    r_starve_cnt <= r_starve_cnt;
                end
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end
    end

endmodule
